// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states,
// iteration limit and a magnitude helper used when latching signed operands.
package muldiv_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  localparam logic [4:0] ITER_LAST = 5'd31;

  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers. Multiply (shift-add)
// and restoring divide share one 64-bit accumulator, operand register and adder.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  EX_Op,
  input  logic [31:0] EX_Rs_Data,
  input  logic [31:0] EX_Rt_Data,
  input  logic        EX_Hold,
  input  logic        EX_Flush,
  output logic        EX_ALU_Stall,
  output logic        Busy,
  output logic [31:0] MF_Data
);

  state_t      state, state_next;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic [31:0] hi, lo;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, is_div;

  logic        op_valid, accept, start_mul, start_div, is_signed;
  logic        sub;
  logic [32:0] add_a;
  logic [33:0] add_b;
  logic [33:0] add_sum;

  assign op_valid  = (EX_Op != OP_NONE) && (EX_Op <= OP_MFLO);
  assign accept    = op_valid && (state == ST_IDLE) && !EX_Hold && !EX_Flush;
  assign start_mul = accept && ((EX_Op == OP_MULT) || (EX_Op == OP_MULTU));
  assign start_div = accept && ((EX_Op == OP_DIV) || (EX_Op == OP_DIVU));
  assign is_signed = (EX_Op == OP_MULT) || (EX_Op == OP_DIV);

  // Divide subtracts the divisor from the shifted partial remainder; bit 33 is the borrow.
  assign sub     = (state == ST_DIV);
  assign add_a   = sub ? acc[63:31] : {1'b0, acc[63:32]};
  assign add_b   = sub ? ~{2'b00, opnd} : {2'b00, opnd};
  assign add_sum = {1'b0, add_a} + add_b + {33'd0, sub};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)      state_next = ST_MUL;
        else if (start_div) state_next = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cnt == ITER_LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy         = (state != ST_IDLE);
    EX_ALU_Stall = Busy && op_valid;
    MF_Data      = 32'd0;
    if (EX_Op == OP_MFHI)      MF_Data = hi;
    else if (EX_Op == OP_MFLO) MF_Data = lo;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= 64'd0;
      opnd   <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      cnt    <= 5'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 5'd0;
          if (accept && EX_Op == OP_MTHI) hi <= EX_Rs_Data;
          if (accept && EX_Op == OP_MTLO) lo <= EX_Rs_Data;
          if (start_mul || start_div) begin
            acc    <= {32'd0, magnitude(start_div ? EX_Rs_Data : EX_Rt_Data, is_signed)};
            opnd   <= magnitude(start_div ? EX_Rt_Data : EX_Rs_Data, is_signed);
            neg_q  <= is_signed && (EX_Rs_Data[31] ^ EX_Rt_Data[31]);
            neg_r  <= is_signed && EX_Rs_Data[31];
            is_div <= start_div;
          end
        end
        ST_MUL: begin
          acc <= acc[0] ? {add_sum[32:0], acc[31:1]} : {1'b0, acc[63:1]};
          cnt <= cnt + 5'd1;
        end
        ST_DIV: begin
          acc <= add_sum[33] ? {acc[62:0], 1'b0} : {add_sum[31:0], acc[30:0], 1'b1};
          cnt <= cnt + 5'd1;
        end
        ST_FIX: begin
          if (is_div) begin
            lo <= neg_q ? (32'd0 - acc[31:0])  : acc[31:0];
            hi <= neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
          end else begin
            {hi, lo} <= neg_q ? (64'd0 - acc) : acc;
          end
        end
        default: cnt <= 5'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  EX_Op;
  logic [31:0] EX_Rs_Data, EX_Rt_Data;
  logic        EX_Hold, EX_Flush;
  logic        EX_ALU_Stall, Busy;
  logic [31:0] MF_Data;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  muldiv_unit dut (
    .clock(clock), .reset_n(reset_n), .EX_Op(EX_Op),
    .EX_Rs_Data(EX_Rs_Data), .EX_Rt_Data(EX_Rt_Data),
    .EX_Hold(EX_Hold), .EX_Flush(EX_Flush),
    .EX_ALU_Stall(EX_ALU_Stall), .Busy(Busy), .MF_Data(MF_Data)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Architectural result of one accepted op, straight from MIPS arithmetic rules.
  function automatic void modelOp(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint      sp;
    logic [63:0] up;
    int          a, b;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(rs)) * longint'($signed(rt));
        {modelHi, modelLo} = sp;
      end
      OP_MULTU: begin
        up = {32'd0, rs} * {32'd0, rt};
        {modelHi, modelLo} = up;
      end
      OP_DIV: begin
        if (rt == 32'd0) begin
          modelLo = rs[31] ? 32'h1 : 32'hFFFFFFFF;
          modelHi = rs;
        end else if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) begin
          modelLo = 32'h80000000;
          modelHi = 32'd0;
        end else begin
          a = rs;
          b = rt;
          modelLo = a / b;
          modelHi = a % b;
        end
      end
      OP_DIVU: begin
        if (rt == 32'd0) begin
          modelLo = 32'hFFFFFFFF;
          modelHi = rs;
        end else begin
          modelLo = rs / rt;
          modelHi = rs % rt;
        end
      end
      OP_MTHI: modelHi = rs;
      OP_MTLO: modelLo = rs;
      default: ;
    endcase
  endfunction

  task automatic checkHiLo(input string tag);
    EX_Op = OP_MFHI;
    #1 checkOutput({tag, ".hi"}, MF_Data, modelHi);
    EX_Op = OP_MFLO;
    #1 checkOutput({tag, ".lo"}, MF_Data, modelLo);
    EX_Op = OP_NONE;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (Busy && n < 60) begin
      n++;
      step();
    end
    checkOutput({tag, ".busycycles"}, n, 33);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input string tag);
    EX_Op = op;
    EX_Rs_Data = rs;
    EX_Rt_Data = rt;
    step();
    EX_Op = OP_NONE;
    modelOp(op, rs, rt);
    if (op >= OP_MULT && op <= OP_DIVU) waitIdle(tag);
    checkHiLo(tag);
  endtask

  logic [3:0]  rop;
  logic [31:0] rrs, rrt, mtVal;

  initial begin
    reset_n = 1'b0;
    EX_Op = OP_NONE;
    EX_Rs_Data = 32'd0;
    EX_Rt_Data = 32'd0;
    EX_Hold = 1'b0;
    EX_Flush = 1'b0;
    #1;
    checkOutput("reset.busy", Busy, 0);
    checkOutput("reset.stall", EX_ALU_Stall, 0);
    checkOutput("reset.mfnone", MF_Data, 0);
    checkHiLo("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    applyStimulus(OP_MULT,  32'hFFFFFFFE, 32'h00000003, "mult_neg");
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    applyStimulus(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, "mult_m1");
    applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'h00000002, "div_neg");
    applyStimulus(OP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_ovf");
    applyStimulus(OP_DIVU,  32'h12345678, 32'h00000000, "divu_zero");
    applyStimulus(OP_DIV,   32'hFFFFFFFB, 32'h00000000, "div_zero_neg");
    applyStimulus(OP_DIV,   32'h00000007, 32'h00000000, "div_zero_pos");
    applyStimulus(OP_MTHI,  32'hCAFEF00D, 32'h0, "mthi");
    applyStimulus(OP_MTLO,  32'h0BADBEEF, 32'h0, "mtlo");

    // MFLO waiting behind a running MULT
    EX_Op = OP_MULT; EX_Rs_Data = 32'd3; EX_Rt_Data = 32'd4;
    step();
    EX_Op = OP_MFLO;
    modelOp(OP_MULT, 32'd3, 32'd4);
    #1;
    begin
      int n = 0;
      while (EX_ALU_Stall && n < 60) begin n++; step(); end
      checkOutput("mflo_stall.cycles", n, 33);
    end
    checkOutput("mflo_stall.data", MF_Data, 32'h0000000C);
    EX_Op = OP_NONE;
    step();

    // MTLO waiting behind a running MULT, applied once it completes
    rrs = $urandom; rrt = $urandom; mtVal = $urandom;
    EX_Op = OP_MULT; EX_Rs_Data = rrs; EX_Rt_Data = rrt;
    step();
    EX_Op = OP_MTLO; EX_Rs_Data = mtVal;
    modelOp(OP_MULT, rrs, rrt);
    #1;
    begin
      int n = 0;
      while (EX_ALU_Stall && n < 60) begin n++; step(); end
      checkOutput("mtlo_stall.cycles", n, 33);
    end
    step();
    EX_Op = OP_NONE;
    modelLo = mtVal;
    checkOutput("mtlo_stall.busy", Busy, 0);
    checkHiLo("mtlo_stall");

    // Flushed op must be ignored
    EX_Op = OP_MULT; EX_Rs_Data = 32'd1234; EX_Rt_Data = 32'd5678; EX_Flush = 1'b1;
    step();
    EX_Op = OP_NONE; EX_Flush = 1'b0;
    checkOutput("flush.busy", Busy, 0);
    checkHiLo("flush");

    // Held op accepted only once hold drops
    EX_Op = OP_MULT; EX_Rs_Data = 32'hFFFF0001; EX_Rt_Data = 32'h00012345; EX_Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("hold.busy", Busy, 0);
    end
    EX_Hold = 1'b0;
    step();
    EX_Op = OP_NONE;
    checkOutput("hold.accept", Busy, 1);
    modelOp(OP_MULT, 32'hFFFF0001, 32'h00012345);
    waitIdle("hold");
    checkHiLo("hold");

    // Reset asserted in the middle of a divide
    EX_Op = OP_DIV; EX_Rs_Data = 32'h7654321F; EX_Rt_Data = 32'h00000013;
    step();
    EX_Op = OP_NONE;
    repeat (9) step();
    checkOutput("midreset.prebusy", Busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset.busy", Busy, 0);
    modelHi = 32'd0;
    modelLo = 32'd0;
    checkHiLo("midreset");
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: rop = OP_MULT;
        1: rop = OP_MULTU;
        2: rop = OP_DIV;
        3: rop = OP_DIVU;
        4: rop = OP_MTHI;
        default: rop = OP_MTLO;
      endcase
      rrs = $urandom;
      case ($urandom_range(0, 7))
        0: rrt = 32'd0;
        1: rrt = 32'hFFFFFFFF;
        2, 3: rrt = $urandom_range(1, 15);
        default: rrt = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) rrs = $urandom_range(0, 100);
      applyStimulus(rop, rrs, rrt, "random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
